// File: rtl/uart_baud_pkg.sv
// Shared baud-rate definitions: rate codes, the 8-entry baud table and the
// round-to-nearest oversample divisor calculation.
package uart_baud_pkg;

  typedef logic [2:0] rate_t;

  localparam rate_t BAUD_1200   = 3'd0;
  localparam rate_t BAUD_2400   = 3'd1;
  localparam rate_t BAUD_4800   = 3'd2;
  localparam rate_t BAUD_9600   = 3'd3;
  localparam rate_t BAUD_19200  = 3'd4;
  localparam rate_t BAUD_38400  = 3'd5;
  localparam rate_t BAUD_57600  = 3'd6;
  localparam rate_t BAUD_115200 = 3'd7;

  localparam int unsigned BAUD_TABLE [8] = '{
    1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200
  };

  // Evaluated at elaboration only; 64-bit so large clock rates cannot wrap.
  function automatic longint unsigned div_calc(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned os);
    longint unsigned den;
    den = longint'(baud) * longint'(os);
    return (longint'(clk_hz) + den / 2) / den;
  endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control and strobe bundle between a baud generator and its UART consumers.
interface baud_tick_gen_if;
  import uart_baud_pkg::*;

  logic  enable;
  rate_t bd_rate;
  logic  restart;
  logic  tick_os;
  logic  tick_tx;
  logic  clk_out;
  rate_t rate_cur;
  logic  rate_pend;

  modport master (
    output enable, bd_rate, restart,
    input  tick_os, tick_tx, clk_out, rate_cur, rate_pend
  );

  modport slave (
    input  enable, bd_rate, restart,
    output tick_os, tick_tx, clk_out, rate_cur, rate_pend
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Oversample/baud strobe generator; all outputs registered, strobes one cycle after terminal count.
// No backpressure: strobes are fire-and-forget, rate changes wait for the next baud boundary.
module baud_tick_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DIV_W       = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  enable,
  input  rate_t bd_rate,
  input  logic  restart,
  output logic  tick_os,
  output logic  tick_tx,
  output logic  clk_out,
  output rate_t rate_cur,
  output logic  rate_pend
);

  localparam int unsigned    OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("baud_tick_gen: OVERSAMPLE must be even and at least 4");
  end

  logic [DIV_W-1:0] div_rom [8];

  for (genvar g = 0; g < 8; g++) begin : g_rom
    localparam longint unsigned D = div_calc(CLK_FREQ_HZ, BAUD_TABLE[g], OVERSAMPLE);
    if (D < 2 || D >= (64'd1 << DIV_W)) begin : g_bad_div
      $error("baud_tick_gen: divisor out of range for DIV_W");
    end
    assign div_rom[g] = DIV_W'(D);
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;
  logic [OS_W-1:0]  os_cnt;
  logic             os_hit;
  logic             tx_hit;

  assign div_last = div_rom[rate_cur] - DIV_W'(1);
  // restart masks the terminal count so a realignment never emits a stray strobe
  assign os_hit   = enable && !restart && (div_cnt == div_last);
  assign tx_hit   = os_hit && (os_cnt == OS_LAST);

  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      div_cnt   <= '0;
      os_cnt    <= '0;
      tick_os   <= 1'b0;
      tick_tx   <= 1'b0;
      clk_out   <= 1'b1;
      rate_cur  <= bd_rate;
      rate_pend <= 1'b0;
    end else begin
      tick_os   <= os_hit;
      tick_tx   <= tx_hit;
      rate_pend <= !tx_hit && (bd_rate != rate_cur);
      if (restart) begin
        div_cnt <= '0;
        os_cnt  <= '0;
        clk_out <= 1'b1;
      end else if (os_hit) begin
        div_cnt <= '0;
        if (tx_hit) begin
          os_cnt   <= '0;
          clk_out  <= 1'b1;
          rate_cur <= bd_rate;
        end else begin
          os_cnt <= os_cnt + OS_W'(1);
          if (os_cnt == OS_HALF) begin
            clk_out <= 1'b0;
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen at 50 MHz / OS=16: divisor table, strobe timing,
// clk_out duty, restart, rate change/cancel, park and reset behaviour.
module tb_baud_tick_gen;
  import uart_baud_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  baud_tick_gen_if bif ();

  baud_tick_gen dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (bif.enable),
    .bd_rate   (bif.bd_rate),
    .restart   (bif.restart),
    .tick_os   (bif.tick_os),
    .tick_tx   (bif.tick_tx),
    .clk_out   (bif.clk_out),
    .rate_cur  (bif.rate_cur),
    .rate_pend (bif.rate_pend)
  );

  typedef struct {
    rate_t rate;
    int    div;
  } vec_t;

  vec_t vecs [8];
  int   total = 0;
  int   bad   = 0;
  int   exp_q [$];
  int   last_n, last_os, last_pend, last_hi;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected strobe is seen (or limit expires, n = -1),
  // accumulating tick_os pulses, rate_pend-high and clk_out-high samples.
  task automatic measure(input bit want_tx, input int limit);
    last_n = -1; last_os = 0; last_pend = 0; last_hi = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      last_os   += int'(bif.tick_os);
      last_pend += int'(bif.rate_pend);
      last_hi   += int'(bif.clk_out);
      if ((want_tx ? bif.tick_tx : bif.tick_os) == 1'b1) begin
        last_n = i;
        break;
      end
    end
  endtask

  task automatic expect_next(input string name, input bit want_tx, input int limit);
    int exp;
    exp = exp_q.pop_front();
    measure(want_tx, limit);
    check(name, last_n, exp);
  endtask

  initial begin
    vecs[0] = '{BAUD_1200,   2604};
    vecs[1] = '{BAUD_2400,   1302};
    vecs[2] = '{BAUD_4800,    651};
    vecs[3] = '{BAUD_9600,    326};
    vecs[4] = '{BAUD_19200,   163};
    vecs[5] = '{BAUD_38400,    81};
    vecs[6] = '{BAUD_57600,    54};
    vecs[7] = '{BAUD_115200,   27};

    bif.enable  = 1'b0;
    bif.bd_rate = 3'd5;
    bif.restart = 1'b0;
    rst         = 1'b0;
    step();
    step();
    check("rst_tick_os",   int'(bif.tick_os),   0);
    check("rst_tick_tx",   int'(bif.tick_tx),   0);
    check("rst_clk_out",   int'(bif.clk_out),   1);
    check("rst_rate_cur",  int'(bif.rate_cur),  5);
    check("rst_rate_pend", int'(bif.rate_pend), 0);
    rst = 1'b1;
    step();

    // First oversample strobe DIV cycles after enable, for every rate code
    for (int i = 0; i < 8; i++) begin
      bif.enable  = 1'b0;
      bif.bd_rate = vecs[i].rate;
      step();
      check("tbl_rate_cur", int'(bif.rate_cur), int'(vecs[i].rate));
      bif.enable = 1'b1;
      exp_q.push_back(vecs[i].div);
      expect_next("tbl_first_os", 1'b0, 3000);
    end

    // Rate 7: first baud strobe, then one full period with duty and tick count
    bif.enable  = 1'b0;
    bif.bd_rate = BAUD_115200;
    step();
    bif.enable = 1'b1;
    exp_q.push_back(432);
    expect_next("r7_first_tx", 1'b1, 1000);
    exp_q.push_back(432);
    expect_next("r7_tx_period", 1'b1, 1000);
    check("r7_clk_hi_cycles", last_hi, 216);
    check("r7_os_per_tx",     last_os, 16);

    // Restart at terminal count suppresses that strobe
    repeat (26) step();
    bif.restart = 1'b1;
    step();
    bif.restart = 1'b0;
    check("restart_no_tick", int'(bif.tick_os), 0);
    check("restart_clk_out", int'(bif.clk_out), 1);
    exp_q.push_back(27);
    expect_next("restart_next_os", 1'b0, 100);

    // Restart during the low half forces clk_out high and realigns the baud period
    for (int i = 0; i < 500 && bif.clk_out !== 1'b0; i++) step();
    check("restart_pre_low", int'(bif.clk_out), 0);
    bif.restart = 1'b1;
    step();
    bif.restart = 1'b0;
    check("restart_clk_hi", int'(bif.clk_out), 1);
    exp_q.push_back(432);
    expect_next("restart_tx_period", 1'b1, 1000);

    // Rate change reverted before the boundary: no effect on timing
    repeat (50) step();
    bif.bd_rate = BAUD_4800;
    step();
    check("cancel_pend_set", int'(bif.rate_pend), 1);
    bif.bd_rate = BAUD_115200;
    step();
    check("cancel_pend_clr", int'(bif.rate_pend), 0);
    exp_q.push_back(380);
    expect_next("cancel_timing", 1'b1, 1000);
    check("cancel_rate_cur", int'(bif.rate_cur), 7);

    // Rate change 7 -> 0 mid-period: applied at the next baud strobe
    repeat (100) step();
    bif.bd_rate = BAUD_1200;
    step();
    check("chg_pend_set", int'(bif.rate_pend), 1);
    check("chg_rate_hold", int'(bif.rate_cur), 7);
    exp_q.push_back(331);
    expect_next("chg_old_boundary", 1'b1, 1000);
    check("chg_pend_held", last_pend, 330);
    check("chg_rate_new",  int'(bif.rate_cur), 0);
    check("chg_pend_done", int'(bif.rate_pend), 0);
    exp_q.push_back(41664);
    expect_next("chg_new_period", 1'b1, 45000);
    check("chg_os_count", last_os, 16);

    // Park, then rate 3 from enable: first strobe plus two exact periods
    bif.enable  = 1'b0;
    bif.bd_rate = BAUD_9600;
    step();
    check("park_rate_cur", int'(bif.rate_cur), 3);
    check("park_pend",     int'(bif.rate_pend), 0);
    bif.enable = 1'b1;
    repeat (3) exp_q.push_back(5216);
    expect_next("r3_first_tx", 1'b1, 6000);
    expect_next("r3_period_a", 1'b1, 6000);
    expect_next("r3_period_b", 1'b1, 6000);
    check("r3_os_per_tx", last_os, 16);

    // enable 1 -> 0 during the low half, restart ignored while parked, then re-enable
    repeat (2700) step();
    check("park_pre_low", int'(bif.clk_out), 0);
    bif.enable  = 1'b0;
    bif.bd_rate = BAUD_115200;
    bif.restart = 1'b1;
    step();
    bif.restart = 1'b0;
    check("park_clk_out", int'(bif.clk_out), 1);
    check("park_tick_os", int'(bif.tick_os), 0);
    check("park_follow",  int'(bif.rate_cur), 7);
    step();
    bif.enable = 1'b1;
    exp_q.push_back(432);
    expect_next("reenable_tx", 1'b1, 1000);

    // Reset mid-period with a pending rate, enable held high
    repeat (260) step();
    check("pre_reset_low", int'(bif.clk_out), 0);
    bif.bd_rate = BAUD_38400;
    step();
    check("pre_reset_pend", int'(bif.rate_pend), 1);
    rst         = 1'b0;
    bif.bd_rate = BAUD_115200;
    step();
    check("mid_rst_clk_out",  int'(bif.clk_out),   1);
    check("mid_rst_tick_tx",  int'(bif.tick_tx),   0);
    check("mid_rst_rate_cur", int'(bif.rate_cur),  7);
    check("mid_rst_pend",     int'(bif.rate_pend), 0);
    rst = 1'b1;
    exp_q.push_back(432);
    expect_next("rst_release_tx", 1'b1, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
